ifetch_ctrl: RTL

- Fetch sequencer for the synchronous instruction memory (1-cycle read latency, word-addressed).
- Owns the fetch PC, drives the memory address, and tracks the one in-flight read.
- Absorbs back-pressure from decode with a 1-entry hold register and handles redirects from branch/jump resolution.
- Sits between the instruction memory and the IF/ID boundary. Presents a valid/ready stream of {pc, instr} to decode.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_if.sv | 27 ++
 rtl/ifetch_skid.sv | 30 +++
 rtl/ifetch_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  // Clear the byte-offset bits of a byte address.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~(32'(INSTR_BYTES) - 32'd1);
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-side bus: redirect input, instruction memory port and the decode stream.
interface ifetch_if #(
  parameter int unsigned ADDR_WIDTH = 10
) ();

  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_pc;
  logic [31:0]           out_instr;

  // Fetch controller side.
  modport master (
    input  redirect_valid, redirect_pc, imem_data, out_ready,
    output imem_addr, out_valid, out_pc, out_instr
  );

  // Environment side (execute, memory, decode).
  modport slave (
    output redirect_valid, redirect_pc, imem_data, out_ready,
    input  imem_addr, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/ifetch_skid.sv
// One-entry hold register for a fetched packet that decode could not take.
module ifetch_skid
  import ifetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       capture,
  input  logic       drain,
  input  fetch_pkt_t cap_pkt,
  output logic       valid,
  output fetch_pkt_t pkt
);

  // Flush beats capture beats drain; capture only occurs while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pkt   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      pkt   <= cap_pkt;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, tracks the single in-flight imem read,
// absorbs decode back-pressure with a one-entry skid and handles redirects.
// Optional performance counters are enabled by defining IFETCH_PERF_EN.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IFETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  ifetch_if.master    bus
);

  logic [31:0] pc_q, pc_d;
  logic        infl_v_q, infl_v_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic [31:0] last_pc_q, last_instr_q;
  logic        hold_v, issue, capture, drain, present;
  logic [31:0] redir_pc;
  fetch_pkt_t  hold_pkt, infl_pkt, pres_pkt;

  assign redir_pc = align_pc(bus.redirect_pc);
  assign infl_pkt = '{pc: infl_pc_q, instr: bus.imem_data};

  ifetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.redirect_valid),
    .capture (capture),
    .drain   (drain),
    .cap_pkt (infl_pkt),
    .valid   (hold_v),
    .pkt     (hold_pkt)
  );

  // Issue/capture/drain decisions and next fetch PC; redirect has top priority.
  always_comb begin
    // Never issue while a returning read could find no room to land.
    issue     = !(hold_v && !bus.out_ready) && !(infl_v_q && !hold_v && !bus.out_ready);
    capture   = infl_v_q && !hold_v && !bus.out_ready && !bus.redirect_valid;
    drain     = hold_v && bus.out_ready;
    pc_d      = pc_q;
    infl_pc_d = infl_pc_q;
    infl_v_d  = 1'b0;
    if (bus.redirect_valid) begin
      infl_v_d  = 1'b1;
      infl_pc_d = redir_pc;
      pc_d      = redir_pc + 32'(INSTR_BYTES);
    end else if (issue) begin
      infl_v_d  = 1'b1;
      infl_pc_d = pc_q;
      pc_d      = pc_q + 32'(INSTR_BYTES);
    end
  end

  // Output mux: held packet first, then the in-flight read; else keep last value.
  always_comb begin
    present       = hold_v || infl_v_q;
    pres_pkt      = hold_v ? hold_pkt : infl_pkt;
    bus.out_valid = present && !bus.redirect_valid;
    bus.out_pc    = present ? pres_pkt.pc : last_pc_q;
    bus.out_instr = present ? pres_pkt.instr : last_instr_q;
    // Address is driven every cycle; a read that is not issued is simply ignored.
    bus.imem_addr = bus.redirect_valid ? bus.redirect_pc[ADDR_WIDTH+1:2]
                                       : pc_q[ADDR_WIDTH+1:2];
  end

  // Fetch PC, in-flight tracking and last-presented packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      infl_v_q     <= 1'b0;
      infl_pc_q    <= '0;
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else begin
      pc_q      <= pc_d;
      infl_v_q  <= infl_v_d;
      infl_pc_q <= infl_pc_d;
      if (present) begin
        last_pc_q    <= pres_pkt.pc;
        last_instr_q <= pres_pkt.instr;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  // Handshake and stall-cycle counters, free-running modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready)  perf_fetched <= perf_fetched + 32'd1;
      if (bus.out_valid && !bus.out_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
